// File: rtl/kled_pkg.sv
// Shared encodings and board timing constants for the key conditioning front-end.
// Imported by the debounce channel and its wrapper.
package kled_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DEB_DN = 2'd1,
        ST_HELD   = 2'd2,
        ST_DEB_UP = 2'd3
    } ch_state_e;

    localparam int unsigned T20MS = 1_000_000;
    localparam int unsigned T1S   = 50_000_000;

    function automatic longint unsigned max_u(
        input longint unsigned a,
        input longint unsigned b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: two-flop synchroniser, debounce FSM and registered event outputs.
// Events are generated in the FSM and re-registered once before leaving the channel.
module key_debounce_ch
    import kled_pkg::*;
#(
    parameter int unsigned DEB_CYCLES  = T20MS,
    parameter int unsigned LONG_CYCLES = T1S,
    parameter int unsigned CNT_W       = 26
) (
    input  logic clk,
    input  logic rstn,
    input  logic key,
    output logic key_press,
    output logic key_release,
    output logic key_long,
    output logic key_level
);

    localparam longint unsigned CNT_CAP  = (64'd1 << CNT_W) - 64'd1;
    localparam longint unsigned CNT_NEED =
        max_u(longint'(DEB_CYCLES), longint'(LONG_CYCLES));

    if (CNT_W < 1 || CNT_W > 32 || CNT_NEED > CNT_CAP) begin : g_bad_cnt_w
        $error("key_debounce_ch: CNT_W too small for DEB/LONG cycles");
    end
    if (DEB_CYCLES < 2 || LONG_CYCLES < 2) begin : g_bad_cycles
        $error("key_debounce_ch: DEB_CYCLES and LONG_CYCLES must be >= 2");
    end

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_CYCLES);

    logic [1:0]       sync_q;
    logic             key_s;
    ch_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] long_cnt_q;
    logic [CNT_W-1:0] long_cnt_d;
    logic             long_hit;
    logic             press_q;
    logic             rel_q;
    logic             long_q;
    logic             level_q;

    // Raw key is active-low; flops reset to the released level.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], key};
        end
    end

    assign key_s = sync_q[1];

    always_comb begin
        long_cnt_d = long_cnt_q;
        if (long_cnt_q != LONG_MAX) begin
            long_cnt_d = long_cnt_q + CNT_ONE;
        end
    end

    assign long_hit = (long_cnt_q == LONG_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            long_cnt_q  <= '0;
            press_q     <= 1'b0;
            rel_q       <= 1'b0;
            long_q      <= 1'b0;
            level_q     <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
            key_level   <= 1'b0;
        end else begin
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            long_q  <= 1'b0;

            unique case (state_q)
                ST_IDLE: begin
                    if (!key_s) begin
                        state_q <= ST_DEB_DN;
                        cnt_q   <= CNT_ONE;
                    end
                end
                ST_DEB_DN: begin
                    if (key_s) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_q    <= ST_HELD;
                        cnt_q      <= '0;
                        long_cnt_q <= '0;
                        press_q    <= 1'b1;
                        level_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_HELD: begin
                    long_cnt_q <= long_cnt_d;
                    long_q     <= long_hit;
                    if (key_s) begin
                        state_q <= ST_DEB_UP;
                        cnt_q   <= CNT_ONE;
                    end
                end
                ST_DEB_UP: begin
                    long_cnt_q <= long_cnt_d;
                    if (!key_s) begin
                        state_q <= ST_HELD;
                        cnt_q   <= '0;
                        long_q  <= long_hit;
                    end else if (cnt_q == DEB_LAST) begin
                        // Accepted release takes precedence over a late long-press.
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        rel_q   <= 1'b1;
                        level_q <= 1'b0;
                    end else begin
                        cnt_q  <= cnt_q + CNT_ONE;
                        long_q <= long_hit;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase

            key_press   <= press_q;
            key_release <= rel_q;
            key_long    <= long_q;
            key_level   <= level_q;
        end
    end

endmodule

// File: rtl/key_debounce.sv
// Push-button front-end: one independent debounce channel per key.
// Pure wrapper; all logic lives in key_debounce_ch.
module key_debounce
    import kled_pkg::*;
#(
    parameter int unsigned KEY_W       = 4,
    parameter int unsigned DEB_CYCLES  = T20MS,
    parameter int unsigned LONG_CYCLES = T1S,
    parameter int unsigned CNT_W       = 26
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [KEY_W-1:0] key,
    output logic [KEY_W-1:0] key_press,
    output logic [KEY_W-1:0] key_release,
    output logic [KEY_W-1:0] key_long,
    output logic [KEY_W-1:0] key_level
);

    for (genvar i = 0; i < int'(KEY_W); i++) begin : g_ch
        key_debounce_ch #(
            .DEB_CYCLES (DEB_CYCLES),
            .LONG_CYCLES(LONG_CYCLES),
            .CNT_W      (CNT_W)
        ) u_ch (
            .clk        (clk),
            .rstn       (rstn),
            .key        (key[i]),
            .key_press  (key_press[i]),
            .key_release(key_release[i]),
            .key_long   (key_long[i]),
            .key_level  (key_level[i])
        );
    end

endmodule
